// File: rtl/kernel3_gmem_A_m_axi_arb_pkg.sv
// Shared types and helpers for the gmem_A read-channel arbiter.
package kernel3_gmem_A_m_axi_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ar_state_e;

  // Upper bound on requesters; rr_pick works on a request vector of this width.
  localparam int MAX_PORTS = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

  // First set bit of req searching upward from ptr, wrapping at n.
  // Returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [2:0]           ptr,
                                         input int                   n);
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n;
      if (req[3'(idx)]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

endpackage

// File: rtl/kernel3_gmem_A_m_axi_arb_fifo.sv
// Order FIFO holding the owner of every accepted read request, show-ahead head.
module kernel3_gmem_A_m_axi_arb_fifo
  import kernel3_gmem_A_m_axi_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Next-state for storage, pointers, count and the registered flags.
  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/kernel3_gmem_a_m_axi_read_arb.sv
// Round-robin arbiter sharing the gmem_A read request channel between
// NUM_PORTS requesters; read data is steered back in issue order.
// Optional macro READ_ARB_PERF_CNT_EN adds grant and stall counters.
//
//   state | meaning
//   IDLE  | no request pending downstream; may grant one requester
//   ISSUE | captured request held on out_HLS_AR* until in_HLS_ARREADY
module kernel3_gmem_a_m_axi_read_arb
  import kernel3_gmem_A_m_axi_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int BUS_ADDR_WIDTH  = 64,
  parameter int BUS_DATA_WIDTH  = 512,
  parameter int NUM_OUTSTANDING = 4
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [NUM_PORTS*BUS_ADDR_WIDTH-1:0] in_P_ARADDR,
  input  logic [NUM_PORTS*32-1:0]             in_P_ARLEN,
  input  logic [NUM_PORTS-1:0]                in_P_ARVALID,
  output logic [NUM_PORTS-1:0]                out_P_ARREADY,
  output logic [BUS_DATA_WIDTH-1:0]           out_P_RDATA,
  output logic [1:0]                          out_P_RLAST,
  output logic [NUM_PORTS-1:0]                out_P_RVALID,
  input  logic [NUM_PORTS-1:0]                in_P_RREADY,
  input  logic [NUM_PORTS-1:0]                in_P_RBUST_READY,
  output logic [BUS_ADDR_WIDTH-1:0]           out_HLS_ARADDR,
  output logic [31:0]                         out_HLS_ARLEN,
  output logic                                out_HLS_ARVALID,
  input  logic                                in_HLS_ARREADY,
  input  logic [BUS_DATA_WIDTH-1:0]           in_HLS_RDATA,
  input  logic [1:0]                          in_HLS_RLAST,
  input  logic                                in_HLS_RVALID,
  output logic                                out_HLS_RREADY,
  output logic                                out_HLS_RBUST_READY
`ifdef READ_ARB_PERF_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]             out_grant_cnt,
  output logic [31:0]                         out_stall_cnt
`endif
);

  localparam int PW = clog2(NUM_PORTS);

  ar_state_e                 state_q, state_d;
  logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [BUS_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [31:0]               arlen_q, arlen_d;
  logic [3:0]                pick;
  logic [PW-1:0]             gnt_idx;
  logic                      grant;
  logic                      fifo_full, fifo_empty;
  logic [PW-1:0]             head;
  logic                      pop;

  assign pick    = rr_pick(MAX_PORTS'(in_P_ARVALID), 3'(rr_ptr_q), NUM_PORTS);
  assign gnt_idx = PW'(pick);
  // The full flag is registered, so a pop in this cycle does not free a slot yet.
  assign grant   = (state_q == IDLE) & pick[3] & ~fifo_full;

  // AR FSM next state, request capture and round-robin pointer update.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          araddr_d = in_P_ARADDR[gnt_idx*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
          arlen_d  = in_P_ARLEN[gnt_idx*32 +: 32];
          rr_ptr_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (in_HLS_ARREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // AR FSM registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
    end
  end

  assign out_HLS_ARVALID = (state_q == ISSUE);
  assign out_HLS_ARADDR  = araddr_q;
  assign out_HLS_ARLEN   = arlen_q;

  // Accept pulse to the granted requester in the grant cycle.
  always_comb begin
    out_P_ARREADY = '0;
    if (grant) out_P_ARREADY[gnt_idx] = 1'b1;
  end

  kernel3_gmem_A_m_axi_arb_fifo #(
    .WIDTH (PW),
    .DEPTH (NUM_OUTSTANDING)
  ) u_order_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (grant),
    .din   (gnt_idx),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Steer read beats to the owner at the head; nothing is accepted when empty.
  always_comb begin
    out_P_RVALID       = '0;
    out_P_RVALID[head] = in_HLS_RVALID & ~fifo_empty;
  end

  assign out_HLS_RREADY      = ~fifo_empty & in_P_RREADY[head];
  assign out_HLS_RBUST_READY = ~fifo_empty & in_P_RBUST_READY[head];
  assign out_P_RDATA         = in_HLS_RDATA;
  assign out_P_RLAST         = in_HLS_RLAST;
  assign pop                 = in_HLS_RVALID & out_HLS_RREADY & in_HLS_RLAST[0];

`ifdef READ_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q [NUM_PORTS];
  logic [31:0] grant_cnt_d [NUM_PORTS];
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating per-port grant count and full-FIFO stall count.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (grant && grant_cnt_q[gnt_idx] != '1)
      grant_cnt_d[gnt_idx] = grant_cnt_q[gnt_idx] + 32'd1;
    if ((|in_P_ARVALID) && fifo_full && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      grant_cnt_q <= '{default: '0};
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Flatten the per-port counters onto the output bus.
  always_comb begin
    out_grant_cnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) out_grant_cnt[i*32 +: 32] = grant_cnt_q[i];
  end

  assign out_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_kernel3_gmem_a_m_axi_read_arb.sv
// Directed bench for the gmem_A read arbiter. Inputs change 1 time unit after
// the rising edge; outputs are sampled 4 units after the rising edge.
module tb_kernel3_gmem_a_m_axi_read_arb;

  localparam int NP = 4;
  localparam int AW = 64;
  localparam int DW = 512;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic [NP*AW-1:0]  in_P_ARADDR;
  logic [NP*32-1:0]  in_P_ARLEN;
  logic [NP-1:0]     in_P_ARVALID;
  logic [NP-1:0]     out_P_ARREADY;
  logic [DW-1:0]     out_P_RDATA;
  logic [1:0]        out_P_RLAST;
  logic [NP-1:0]     out_P_RVALID;
  logic [NP-1:0]     in_P_RREADY;
  logic [NP-1:0]     in_P_RBUST_READY;
  logic [AW-1:0]     out_HLS_ARADDR;
  logic [31:0]       out_HLS_ARLEN;
  logic              out_HLS_ARVALID;
  logic              in_HLS_ARREADY;
  logic [DW-1:0]     in_HLS_RDATA;
  logic [1:0]        in_HLS_RLAST;
  logic              in_HLS_RVALID;
  logic              out_HLS_RREADY;
  logic              out_HLS_RBUST_READY;
`ifdef READ_ARB_PERF_CNT_EN
  logic [NP*32-1:0]  out_grant_cnt;
  logic [31:0]       out_stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] addr_tab [NP];
  logic [31:0] len_tab  [NP];

  kernel3_gmem_a_m_axi_read_arb #(
    .NUM_PORTS       (NP),
    .BUS_ADDR_WIDTH  (AW),
    .BUS_DATA_WIDTH  (DW),
    .NUM_OUTSTANDING (4)
  ) dut (
    .ACLK                (ACLK),
    .ARESETN             (ARESETN),
    .in_P_ARADDR         (in_P_ARADDR),
    .in_P_ARLEN          (in_P_ARLEN),
    .in_P_ARVALID        (in_P_ARVALID),
    .out_P_ARREADY       (out_P_ARREADY),
    .out_P_RDATA         (out_P_RDATA),
    .out_P_RLAST         (out_P_RLAST),
    .out_P_RVALID        (out_P_RVALID),
    .in_P_RREADY         (in_P_RREADY),
    .in_P_RBUST_READY    (in_P_RBUST_READY),
    .out_HLS_ARADDR      (out_HLS_ARADDR),
    .out_HLS_ARLEN       (out_HLS_ARLEN),
    .out_HLS_ARVALID     (out_HLS_ARVALID),
    .in_HLS_ARREADY      (in_HLS_ARREADY),
    .in_HLS_RDATA        (in_HLS_RDATA),
    .in_HLS_RLAST        (in_HLS_RLAST),
    .in_HLS_RVALID       (in_HLS_RVALID),
    .out_HLS_RREADY      (out_HLS_RREADY),
    .out_HLS_RBUST_READY (out_HLS_RBUST_READY)
`ifdef READ_ARB_PERF_CNT_EN
    ,
    .out_grant_cnt       (out_grant_cnt),
    .out_stall_cnt       (out_stall_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    ARESETN          = 1'b0;
    in_P_ARVALID     = '0;
    in_P_RREADY      = '1;
    in_P_RBUST_READY = '1;
    in_HLS_ARREADY   = 1'b0;
    in_HLS_RDATA     = '0;
    in_HLS_RLAST     = 2'b11;
    in_HLS_RVALID    = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    settle();
    n_vec++; if (out_HLS_ARVALID !== 1'b0) begin n_err++; $display("FAIL reset_arvalid got=%b exp=0", out_HLS_ARVALID); end
    n_vec++; if (out_HLS_ARADDR !== 64'h0) begin n_err++; $display("FAIL reset_araddr got=%h exp=0", out_HLS_ARADDR); end
    n_vec++; if (out_HLS_ARLEN !== 32'h0) begin n_err++; $display("FAIL reset_arlen got=%h exp=0", out_HLS_ARLEN); end
    n_vec++; if (out_P_ARREADY !== 4'b0000) begin n_err++; $display("FAIL reset_p_arready got=%b exp=0000", out_P_ARREADY); end
    n_vec++; if (out_P_RVALID !== 4'b0000) begin n_err++; $display("FAIL reset_p_rvalid got=%b exp=0000", out_P_RVALID); end
    n_vec++; if (out_HLS_RREADY !== 1'b0) begin n_err++; $display("FAIL reset_rready got=%b exp=0", out_HLS_RREADY); end
    n_vec++; if (out_HLS_RBUST_READY !== 1'b0) begin n_err++; $display("FAIL reset_rbust got=%b exp=0", out_HLS_RBUST_READY); end
    ARESETN = 1'b1;
    tick();
    settle();
    n_vec++; if (out_HLS_RREADY !== 1'b0) begin n_err++; $display("FAIL empty_rvalid_rready got=%b exp=0", out_HLS_RREADY); end
    n_vec++; if (out_P_RVALID !== 4'b0000) begin n_err++; $display("FAIL empty_rvalid_steer got=%b exp=0000", out_P_RVALID); end
    in_HLS_RVALID = 1'b0;
    in_HLS_RLAST  = 2'b00;
  endtask

  task automatic test_single();
    logic [1:0]    exp_last;
    logic [DW-1:0] exp_data;
    tick();
    in_P_ARVALID = 4'b0100;
    settle();
    n_vec++; if (out_P_ARREADY !== 4'b0100) begin n_err++; $display("FAIL single_arready got=%b exp=0100", out_P_ARREADY); end
    n_vec++; if (out_HLS_ARVALID !== 1'b0) begin n_err++; $display("FAIL single_arvalid_t0 got=%b exp=0", out_HLS_ARVALID); end
    tick();
    in_P_ARVALID = '0;
    settle();
    n_vec++; if (out_HLS_ARVALID !== 1'b1) begin n_err++; $display("FAIL single_arvalid_t1 got=%b exp=1", out_HLS_ARVALID); end
    n_vec++; if (out_HLS_ARADDR !== 64'h1000) begin n_err++; $display("FAIL single_araddr got=%h exp=1000", out_HLS_ARADDR); end
    n_vec++; if (out_HLS_ARLEN !== 32'h40) begin n_err++; $display("FAIL single_arlen got=%h exp=40", out_HLS_ARLEN); end
    n_vec++; if (out_P_ARREADY !== 4'b0000) begin n_err++; $display("FAIL single_no_grant_in_issue got=%b exp=0000", out_P_ARREADY); end
    tick();
    in_HLS_ARREADY = 1'b1;
    settle();
    n_vec++; if (out_HLS_ARVALID !== 1'b1 || out_HLS_ARADDR !== 64'h1000) begin n_err++; $display("FAIL single_ar_hold got=%b/%h exp=1/1000", out_HLS_ARVALID, out_HLS_ARADDR); end
    tick();
    in_HLS_ARREADY = 1'b0;
    settle();
    n_vec++; if (out_HLS_ARVALID !== 1'b0) begin n_err++; $display("FAIL single_ar_done got=%b exp=0", out_HLS_ARVALID); end
    for (int b = 0; b < 4; b++) begin
      tick();
      exp_last         = (b == 3) ? 2'b11 : ((b == 1) ? 2'b10 : 2'b00);
      exp_data         = {8{64'hBEEF_0000 + 64'(b)}};
      in_HLS_RVALID    = 1'b1;
      in_HLS_RLAST     = exp_last;
      in_HLS_RDATA     = exp_data;
      in_P_RBUST_READY = (b == 0) ? 4'b1011 : 4'b0100;
      settle();
      n_vec++; if (out_P_RVALID !== 4'b0100) begin n_err++; $display("FAIL single_rvalid beat=%0d got=%b exp=0100", b, out_P_RVALID); end
      n_vec++; if (out_HLS_RREADY !== 1'b1) begin n_err++; $display("FAIL single_rready beat=%0d got=%b exp=1", b, out_HLS_RREADY); end
      n_vec++; if (out_P_RDATA !== exp_data || out_P_RLAST !== exp_last) begin n_err++; $display("FAIL single_rdata beat=%0d got=%h/%b exp=%h/%b", b, out_P_RDATA[63:0], out_P_RLAST, exp_data[63:0], exp_last); end
      n_vec++; if (out_HLS_RBUST_READY !== (b != 0)) begin n_err++; $display("FAIL single_rbust beat=%0d got=%b exp=%b", b, out_HLS_RBUST_READY, (b != 0)); end
    end
    tick();
    in_HLS_RLAST = 2'b00;
    settle();
    n_vec++; if (out_HLS_RREADY !== 1'b0 || out_P_RVALID !== 4'b0000) begin n_err++; $display("FAIL single_fifo_empty got=%b/%b exp=0/0000", out_HLS_RREADY, out_P_RVALID); end
    in_HLS_RVALID    = 1'b0;
    in_P_RBUST_READY = '1;
  endtask

  task automatic test_ordering();
    tick();
    in_P_ARVALID   = 4'b1001;
    in_HLS_ARREADY = 1'b1;
    settle();
    n_vec++; if (out_P_ARREADY !== 4'b1000) begin n_err++; $display("FAIL order_grant3 got=%b exp=1000", out_P_ARREADY); end
    tick();
    settle();
    n_vec++; if (out_P_ARREADY !== 4'b0000 || out_HLS_ARADDR !== 64'hD300) begin n_err++; $display("FAIL order_issue3 got=%b/%h exp=0000/d300", out_P_ARREADY, out_HLS_ARADDR); end
    tick();
    settle();
    n_vec++; if (out_P_ARREADY !== 4'b0001) begin n_err++; $display("FAIL order_grant0 got=%b exp=0001", out_P_ARREADY); end
    tick();
    in_P_ARVALID = '0;
    settle();
    n_vec++; if (out_HLS_ARVALID !== 1'b1 || out_HLS_ARADDR !== 64'hA000) begin n_err++; $display("FAIL order_issue0 got=%b/%h exp=1/a000", out_HLS_ARVALID, out_HLS_ARADDR); end
    tick();
    in_HLS_ARREADY = 1'b0;
    in_HLS_RVALID  = 1'b1;
    in_HLS_RLAST   = 2'b10;
    settle();
    n_vec++; if (out_P_RVALID !== 4'b1000) begin n_err++; $display("FAIL order_burst_end got=%b exp=1000", out_P_RVALID); end
    tick();
    in_HLS_RLAST = 2'b11;
    settle();
    n_vec++; if (out_P_RVALID !== 4'b1000) begin n_err++; $display("FAIL order_head_kept got=%b exp=1000", out_P_RVALID); end
    tick();
    in_HLS_RLAST     = 2'b00;
    in_HLS_RDATA     = {8{64'h5A5A_0001}};
    in_P_RREADY      = 4'b1110;
    in_P_RBUST_READY = 4'b1110;
    settle();
    n_vec++; if (out_P_RVALID !== 4'b0001) begin n_err++; $display("FAIL order_next_owner got=%b exp=0001", out_P_RVALID); end
    n_vec++; if (out_HLS_RREADY !== 1'b0 || out_HLS_RBUST_READY !== 1'b0) begin n_err++; $display("FAIL backpressure_rready got=%b/%b exp=0/0", out_HLS_RREADY, out_HLS_RBUST_READY); end
    tick();
    settle();
    n_vec++; if (out_P_RVALID !== 4'b0001 || out_P_RDATA[63:0] !== 64'h5A5A_0001) begin n_err++; $display("FAIL backpressure_hold got=%b/%h exp=0001/5a5a0001", out_P_RVALID, out_P_RDATA[63:0]); end
    tick();
    in_P_RREADY      = '1;
    in_P_RBUST_READY = '1;
    in_HLS_RLAST     = 2'b11;
    settle();
    n_vec++; if (out_HLS_RREADY !== 1'b1 || out_P_RVALID !== 4'b0001) begin n_err++; $display("FAIL backpressure_release got=%b/%b exp=1/0001", out_HLS_RREADY, out_P_RVALID); end
    tick();
    in_HLS_RVALID = 1'b0;
    in_HLS_RLAST  = 2'b00;
    settle();
  endtask

  task automatic test_full();
    int exp_g [4];
    exp_g = '{2, 3, 0, 2};
    in_HLS_ARREADY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) in_P_ARVALID = 4'b1101;
      settle();
      n_vec++; if (out_P_ARREADY !== (4'b0001 << exp_g[k])) begin n_err++; $display("FAIL full_fill k=%0d got=%b exp=port%0d", k, out_P_ARREADY, exp_g[k]); end
      tick();
    end
    tick();
    in_P_ARVALID = 4'b0010;
    for (int j = 0; j < 3; j++) begin
      settle();
      n_vec++; if (out_P_ARREADY !== 4'b0000) begin n_err++; $display("FAIL full_no_grant j=%0d got=%b exp=0000", j, out_P_ARREADY); end
`ifdef READ_ARB_PERF_CNT_EN
      n_vec++; if (out_stall_cnt !== 32'(1 + j)) begin n_err++; $display("FAIL full_stall_cnt j=%0d got=%0d exp=%0d", j, out_stall_cnt, 1 + j); end
`endif
      tick();
    end
    in_HLS_RVALID = 1'b1;
    in_HLS_RLAST  = 2'b11;
    settle();
    n_vec++; if (out_P_RVALID !== 4'b0100) begin n_err++; $display("FAIL full_head got=%b exp=0100", out_P_RVALID); end
    n_vec++; if (out_P_ARREADY !== 4'b0000) begin n_err++; $display("FAIL full_pop_same_cycle got=%b exp=0000", out_P_ARREADY); end
`ifdef READ_ARB_PERF_CNT_EN
    n_vec++; if (out_grant_cnt !== {32'd2, 32'd3, 32'd0, 32'd2}) begin n_err++; $display("FAIL grant_cnt got=%h exp=00000002_00000003_00000000_00000002", out_grant_cnt); end
`endif
    tick();
    in_HLS_RVALID = 1'b0;
    in_HLS_RLAST  = 2'b00;
    settle();
    n_vec++; if (out_P_ARREADY !== 4'b0010) begin n_err++; $display("FAIL full_after_pop got=%b exp=0010", out_P_ARREADY); end
`ifdef READ_ARB_PERF_CNT_EN
    n_vec++; if (out_stall_cnt !== 32'd5) begin n_err++; $display("FAIL stall_cnt_final got=%0d exp=5", out_stall_cnt); end
`endif
    tick();
    in_P_ARVALID = '0;
    settle();
    n_vec++; if (out_HLS_ARVALID !== 1'b1 || out_HLS_ARADDR !== 64'hB100 || out_HLS_ARLEN !== 32'h20) begin n_err++; $display("FAIL full_port1_issue got=%b/%h/%h exp=1/b100/20", out_HLS_ARVALID, out_HLS_ARADDR, out_HLS_ARLEN); end
    tick();
    settle();
  endtask

  task automatic test_reset_mid();
    tick();
    ARESETN = 1'b0;
    settle();
    ARESETN = 1'b1;
    tick();
    in_HLS_ARREADY = 1'b1;
    in_P_ARVALID   = 4'b0010;
    settle();
    n_vec++; if (out_P_ARREADY !== 4'b0010) begin n_err++; $display("FAIL rstmid_grant1 got=%b exp=0010", out_P_ARREADY); end
    tick();
    in_P_ARVALID = 4'b0100;
    settle();
    tick();
    settle();
    n_vec++; if (out_P_ARREADY !== 4'b0100) begin n_err++; $display("FAIL rstmid_grant2 got=%b exp=0100", out_P_ARREADY); end
    tick();
    in_P_ARVALID   = '0;
    in_HLS_ARREADY = 1'b0;
    settle();
    n_vec++; if (out_HLS_ARVALID !== 1'b1) begin n_err++; $display("FAIL rstmid_in_issue got=%b exp=1", out_HLS_ARVALID); end
    ARESETN = 1'b0;
    #1;
    n_vec++; if (out_HLS_ARVALID !== 1'b0 || out_HLS_ARADDR !== 64'h0) begin n_err++; $display("FAIL rstmid_async got=%b/%h exp=0/0", out_HLS_ARVALID, out_HLS_ARADDR); end
    tick();
    ARESETN       = 1'b1;
    in_HLS_RVALID = 1'b1;
    in_HLS_RLAST  = 2'b11;
    settle();
    n_vec++; if (out_HLS_RREADY !== 1'b0 || out_P_RVALID !== 4'b0000) begin n_err++; $display("FAIL rstmid_fifo_empty got=%b/%b exp=0/0000", out_HLS_RREADY, out_P_RVALID); end
    in_HLS_RVALID = 1'b0;
    in_HLS_RLAST  = 2'b00;
  endtask

  task automatic test_fairness();
    int g;
    in_HLS_ARREADY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      tick();
      if (k == 0) in_P_ARVALID = 4'b1111;
      in_HLS_RVALID = 1'b0;
      settle();
      n_vec++; if (out_P_ARREADY !== (4'b0001 << g)) begin n_err++; $display("FAIL fair_grant k=%0d got=%b exp=port%0d", k, out_P_ARREADY, g); end
      tick();
      in_HLS_RVALID = 1'b1;
      in_HLS_RLAST  = 2'b11;
      settle();
      n_vec++; if (out_P_ARREADY !== 4'b0000 || out_P_RVALID !== (4'b0001 << g)) begin n_err++; $display("FAIL fair_issue k=%0d got=%b/%b exp=0000/port%0d", k, out_P_ARREADY, out_P_RVALID, g); end
    end
    tick();
    in_P_ARVALID  = '0;
    in_HLS_RVALID = 1'b0;
    in_HLS_RLAST  = 2'b00;
  endtask

  initial begin
    addr_tab = '{64'hA000, 64'hB100, 64'h1000, 64'hD300};
    len_tab  = '{32'h10, 32'h20, 32'h40, 32'h80};
    for (int i = 0; i < NP; i++) begin
      in_P_ARADDR[i*AW +: AW] = addr_tab[i];
      in_P_ARLEN[i*32 +: 32]  = len_tab[i];
    end
    test_reset();
    test_single();
    test_ordering();
    test_full();
    test_reset_mid();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/kernel3_gmem_a_m_axi_read_arb.md
Name: kernel3_gmem_A_m_axi_read_arb

Overview:
Round-robin arbiter that shares one HLS-internal read request channel of the gmem_A m_axi read engine between NUM_PORTS HLS read requesters. It serialises AR requests and records the owner of each accepted request in an order FIFO. It then steers returned read data and the 2-bit RLAST flags back to the owning requester in issue order. It sits between the kernel datapath ports and the read engine's in_HLS_* / out_HLS_* side.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
BUS_ADDR_WIDTH, 64, byte address width
BUS_DATA_WIDTH, 512, read data width
NUM_OUTSTANDING, 4, max requests in flight (power of two); order-FIFO depth

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
in_P_ARADDR  in  NUM_PORTS*BUS_ADDR_WIDTH  per-port request address, port i at slice i
in_P_ARLEN  in  NUM_PORTS*32  per-port request byte length field
in_P_ARVALID  in  NUM_PORTS  per-port request valid
out_P_ARREADY  out  NUM_PORTS  per-port request accept
out_P_RDATA  out  BUS_DATA_WIDTH  read data, broadcast to all ports
out_P_RLAST  out  2  {burst_end, request_end}, broadcast
out_P_RVALID  out  NUM_PORTS  one-hot data valid for the owning port
in_P_RREADY  in  NUM_PORTS  per-port data ready
in_P_RBUST_READY  in  NUM_PORTS  per-port burst-ready
out_HLS_ARADDR  out  BUS_ADDR_WIDTH  to read engine
out_HLS_ARLEN  out  32  to read engine
out_HLS_ARVALID  out  1  to read engine
in_HLS_ARREADY  in  1  from read engine
in_HLS_RDATA  in  BUS_DATA_WIDTH  from read engine
in_HLS_RLAST  in  2  from read engine
in_HLS_RVALID  in  1  from read engine
out_HLS_RREADY  out  1  to read engine
out_HLS_RBUST_READY  out  1  to read engine

Behaviour:
- Reset (ARESETN low, async assert, sync deassert): FSM=IDLE; rr_ptr=0; order FIFO empty; out_HLS_ARVALID=0; ARADDR/ARLEN=0; all out_P_ARREADY=0; out_P_RVALID=0; out_HLS_RREADY=0; out_HLS_RBUST_READY=0.
- AR FSM has two states, IDLE and ISSUE.
- IDLE: when any in_P_ARVALID is high and the order FIFO is not full, grant the first valid port searching from rr_ptr upward with wrap.
  - Same cycle: pulse out_P_ARREADY[g]=1.
  - Capture ADDR/LEN into the output registers and set out_HLS_ARVALID=1 on the next edge.
  - Push g into the order FIFO.
  - Set rr_ptr=(g+1) mod NUM_PORTS.
  - Go to ISSUE.
- ISSUE: hold ARVALID, ARADDR and ARLEN stable until in_HLS_ARREADY=1. On that handshake, clear ARVALID and return to IDLE. No back-to-back grant in the handshake cycle; max issue rate is one request per 2 cycles.
- Latency: requester ARVALID to out_HLS_ARVALID is 1 cycle.
- Order FIFO full (NUM_OUTSTANDING entries): no grant and no ARREADY. Requests wait; fairness order is preserved.
- R steering is combinational, with no added latency.
  - head = order FIFO head; hv = FIFO not empty.
  - out_P_RVALID[head] = in_HLS_RVALID & hv; all other bits are 0.
  - out_HLS_RREADY = hv & in_P_RREADY[head].
  - out_HLS_RBUST_READY = hv & in_P_RBUST_READY[head].
  - RDATA and RLAST pass through to all ports.
- Pop: the order FIFO pops on in_HLS_RVALID & out_HLS_RREADY & in_HLS_RLAST[0].
- Simultaneous push and pop: both take effect and the count is unchanged. A push into a full FIFO whose pop happens in the same cycle is not granted; the full flag is registered.
- RVALID with an empty FIFO is a protocol error: RREADY stays 0, so the data is held off.
- Width rules: rr_ptr and FIFO entries are $clog2(NUM_PORTS) bits. FIFO count is $clog2(NUM_OUTSTANDING)+1 bits.

Optional Feature:
- Macro READ_ARB_PERF_CNT_EN.
- Defined: adds output out_grant_cnt (NUM_PORTS*32), holding per-port 32-bit saturating counts of granted requests, and output out_stall_cnt (32), counting cycles where some ARVALID was high but the FIFO was full. Both reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package kernel3_gmem_A_m_axi_arb_pkg holds:
  - localparam functions clog2 and rr_pick (round-robin first-set search);
  - the FSM state encoding IDLE=1'b0, ISSUE=1'b1.
- One sub-module, kernel3_gmem_A_m_axi_arb_fifo: the order FIFO with async active-low reset, registered full and empty, and show-ahead head output.

Test Plan:
- Single request: port 2 sends ADDR=0x1000, LEN=0x40 → ARREADY[2] pulses at T0. out_HLS_ARVALID=1 with ADDR=0x1000 at T1. After 4 data beats ending with RLAST=2'b11, only RVALID[2] toggles and the FIFO is empty afterwards.
- Fairness: ports 0–3 all valid continuously → grant order is 0,1,2,3,0. rr_ptr wraps from 3 to 0.
- Full: 4 grants with no R returns, then port 1 valid → no ARREADY[1] and stall_cnt increments each cycle. One request_end beat → grant to port 1 on the next IDLE cycle.
- Ordering: port 3 is granted, then port 0. Data carries RLAST=2'b10 mid-request → the head stays 3; beats route to port 0 only after RLAST=2'b11.
- Backpressure: in_P_RREADY[head]=0 → out_HLS_RREADY=0; data is not lost and RVALID stays asserted.
- Reset mid-operation: deassert ARESETN while in ISSUE with 2 entries → ARVALID=0 asynchronously, FIFO empty and rr_ptr=0 after release.
